// File: rtl/move_list_collector.sv
// move_list_collector: scans one square's 16 direction move words per batch,
// drops empty words and queues the rest in a first-word-fall-through FIFO
// that the move ordering logic drains over a valid/ready stream.
module move_list_collector #(
  parameter int DEPTH     = 16,
  parameter int NUM_SLOTS = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      batch_valid,
  output logic                      batch_ready,
  input  logic [32*NUM_SLOTS-1:0]   batch_moves,
  output logic                      move_valid,
  input  logic                      move_ready,
  output logic [31:0]               move_data,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [15:0]               move_count,
  output logic                      capture_seen,
  output logic                      batch_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // A move word captures something when its captured-piece field is nonzero.
  function automatic logic is_capture(input logic [31:0] word);
    return (word[29:24] != 6'd0);
  endfunction

  state_t                    state_r, state_s;
  logic [3:0]                idx_r, idx_s;
  logic [32*NUM_SLOTS-1:0]   slots_r;
  logic                      ready_r;
  logic                      done_r, done_s;
  logic                      load_s, push_s, pop_s, full_s;
  logic [31:0]               cur_word_s;
  logic [31:0]               mem_r [DEPTH];
  logic [PW-1:0]             wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]             level_r;
  logic [15:0]               count_r;
  logic                      capture_r;

  assign cur_word_s = slots_r[int'(idx_r)*32 +: 32];
  assign full_s     = (level_r == LW'(DEPTH));
  assign pop_s      = (level_r != {LW{1'b0}}) && move_ready;

  // Next-state logic: accept in IDLE, skip/push/stall one slot per cycle in SCAN.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    load_s  = 1'b0;
    push_s  = 1'b0;
    done_s  = 1'b0;
    if (clear) begin
      state_s = IDLE;
      idx_s   = 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (batch_valid && ready_r) begin
            load_s  = 1'b1;
            idx_s   = 4'd0;
            state_s = SCAN;
          end else begin
            state_s = IDLE;
          end
        end
        SCAN: begin
          // Full test uses pre-edge occupancy, so a same-cycle pop cannot free the slot.
          if ((cur_word_s == 32'h0000_0000) || !full_s) begin
            push_s = (cur_word_s != 32'h0000_0000);
            if (idx_r == 4'(NUM_SLOTS - 1)) begin
              state_s = IDLE;
              idx_s   = 4'd0;
              done_s  = 1'b1;
            end else begin
              idx_s = idx_r + 4'd1;
            end
          end else begin
            idx_s = idx_r;
          end
        end
        default: begin
          state_s = IDLE;
          idx_s   = 4'd0;
        end
      endcase
    end
  end

  // FSM state, slot index, handshake ready and completion pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      idx_r   <= 4'd0;
      ready_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      ready_r <= (state_s == IDLE);
      done_r  <= done_s;
    end
  end

  // Slot register captures the whole batch on acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slots_r <= '0;
    end else if (load_s) begin
      slots_r <= batch_moves;
    end else begin
      slots_r <= slots_r;
    end
  end

  // FIFO storage; contents are only observable through the level-gated head.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= cur_word_s;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Saturating push counter and sticky capture flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r   <= 16'd0;
      capture_r <= 1'b0;
    end else if (clear) begin
      count_r   <= 16'd0;
      capture_r <= 1'b0;
    end else begin
      if (push_s && (count_r != 16'hFFFF)) count_r <= count_r + 16'd1;
      if (push_s && is_capture(cur_word_s)) capture_r <= 1'b1;
    end
  end

  assign batch_ready  = ready_r;
  assign batch_done   = done_r;
  assign fifo_level   = level_r;
  assign move_count   = count_r;
  assign capture_seen = capture_r;
  assign move_valid   = (level_r != {LW{1'b0}});
  assign move_data    = move_valid ? mem_r[rd_ptr_r] : 32'h0000_0000;

endmodule

// File: tb/tb_move_list_collector.sv
// Directed testbench for move_list_collector (FIFO depth 4 so backpressure is reachable).
module tb_move_list_collector;

  logic         clk;
  logic         reset_n;
  logic         clear;
  logic         batch_valid;
  logic         batch_ready;
  logic [511:0] batch_moves;
  logic         move_valid;
  logic         move_ready;
  logic [31:0]  move_data;
  logic [2:0]   fifo_level;
  logic [15:0]  move_count;
  logic         capture_seen;
  logic         batch_done;

  int total = 0;
  int bad   = 0;

  move_list_collector #(.DEPTH(4), .NUM_SLOTS(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .batch_valid  (batch_valid),
    .batch_ready  (batch_ready),
    .batch_moves  (batch_moves),
    .move_valid   (move_valid),
    .move_ready   (move_ready),
    .move_data    (move_data),
    .fifo_level   (fifo_level),
    .move_count   (move_count),
    .capture_seen (capture_seen),
    .batch_done   (batch_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    batch_moves = '0;
    for (int k = 0; k < 6; k++) batch_moves[32*k +: 32] = 32'h0100_0000 + 32'(k) + 32'd1;
    move_ready  = 1'b0;
    batch_valid = 1'b1;
    tick();
    batch_valid = 1'b0;
    tick(); tick(); tick();
    total++; if (fifo_level !== 3'd3) begin bad++; $display("FAIL rst_pre_level: got %0d want 3", fifo_level); end
    total++; if (capture_seen !== 1'b1) begin bad++; $display("FAIL rst_pre_capture: got %b want 1", capture_seen); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (batch_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", batch_ready); end
    total++; if (move_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", move_valid); end
    total++; if (move_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", move_data); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    total++; if (move_count !== 16'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", move_count); end
    total++; if (capture_seen !== 1'b0) begin bad++; $display("FAIL rst_capture: got %b want 0", capture_seen); end
    total++; if (batch_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", batch_done); end
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    total++; if (batch_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", batch_ready); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rst_release_level: got %0d want 0", fifo_level); end
    total++; if (move_valid !== 1'b0) begin bad++; $display("FAIL rst_release_valid: got %b want 0", move_valid); end
  endtask

  task automatic test_sparse();
    logic        exp_valid;
    logic [31:0] exp_data;
    batch_moves = '0;
    batch_moves[32*1 +: 32] = 32'h0015_1814;
    batch_moves[32*4 +: 32] = 32'h1015_1814;
    batch_moves[32*9 +: 32] = 32'h002B_1814;
    move_ready  = 1'b1;
    batch_valid = 1'b1;
    tick();
    batch_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_valid = (k == 2) || (k == 5) || (k == 10);
      exp_data  = (k == 2) ? 32'h0015_1814 : (k == 5) ? 32'h1015_1814 : 32'h002B_1814;
      total++; if (move_valid !== exp_valid) begin bad++; $display("FAIL sparse_valid E%0d: got %b want %b", k, move_valid, exp_valid); end
      if (exp_valid) begin
        total++; if (move_data !== exp_data) begin bad++; $display("FAIL sparse_data E%0d: got %h want %h", k, move_data, exp_data); end
      end
      total++; if (batch_done !== (k == 16)) begin bad++; $display("FAIL sparse_done E%0d: got %b", k, batch_done); end
      total++; if (batch_ready !== (k == 16)) begin bad++; $display("FAIL sparse_ready E%0d: got %b", k, batch_ready); end
    end
    total++; if (move_count !== 16'd3) begin bad++; $display("FAIL sparse_count: got %0d want 3", move_count); end
    total++; if (capture_seen !== 1'b1) begin bad++; $display("FAIL sparse_capture: got %b want 1", capture_seen); end
    tick();
    total++; if (batch_done !== 1'b0) begin bad++; $display("FAIL sparse_done_pulse: got %b want 0", batch_done); end
  endtask

  task automatic test_empty();
    pulse_clear();
    total++; if (move_count !== 16'd0) begin bad++; $display("FAIL clear_count: got %0d want 0", move_count); end
    total++; if (capture_seen !== 1'b0) begin bad++; $display("FAIL clear_capture: got %b want 0", capture_seen); end
    batch_moves = '0;
    batch_valid = 1'b1;
    tick();
    batch_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      total++; if (move_valid !== 1'b0) begin bad++; $display("FAIL empty_valid E%0d: got %b want 0", k, move_valid); end
      total++; if (batch_done !== (k == 16)) begin bad++; $display("FAIL empty_done E%0d: got %b", k, batch_done); end
    end
    total++; if (move_count !== 16'd0) begin bad++; $display("FAIL empty_count: got %0d want 0", move_count); end
    total++; if (capture_seen !== 1'b0) begin bad++; $display("FAIL empty_capture: got %b want 0", capture_seen); end
  endtask

  task automatic test_backpressure();
    logic [31:0] wb [6];
    logic        seen;
    pulse_clear();
    move_ready  = 1'b0;
    batch_moves = '0;
    for (int k = 0; k < 6; k++) begin
      wb[k] = 32'h0000_1000 + 32'(k);
      batch_moves[32*k +: 32] = wb[k];
    end
    batch_valid = 1'b1;
    tick();
    batch_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++; if (fifo_level !== 3'(k)) begin bad++; $display("FAIL bp_fill E%0d: got %0d want %0d", k, fifo_level, k); end
    end
    tick(); tick();
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL bp_stall_level: got %0d want 4", fifo_level); end
    total++; if (batch_done !== 1'b0) begin bad++; $display("FAIL bp_stall_done: got %b want 0", batch_done); end
    total++; if (batch_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready: got %b want 0", batch_ready); end
    total++; if (move_data !== wb[0]) begin bad++; $display("FAIL bp_head0: got %h want %h", move_data, wb[0]); end
    move_ready = 1'b1;
    tick();
    move_ready = 1'b0;
    total++; if (fifo_level !== 3'd3) begin bad++; $display("FAIL bp_pop_level: got %0d want 3", fifo_level); end
    total++; if (move_data !== wb[1]) begin bad++; $display("FAIL bp_head1: got %h want %h", move_data, wb[1]); end
    tick();
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL bp_refill_level: got %0d want 4", fifo_level); end
    tick();
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL bp_restall_level: got %0d want 4", fifo_level); end
    move_ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      total++; if (move_valid !== 1'b1) begin bad++; $display("FAIL bp_drain_valid %0d: got %b want 1", j, move_valid); end
      total++; if (move_data !== wb[j]) begin bad++; $display("FAIL bp_drain_data %0d: got %h want %h", j, move_data, wb[j]); end
      tick();
    end
    total++; if (move_valid !== 1'b0) begin bad++; $display("FAIL bp_drained: got %b want 0", move_valid); end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (batch_done) seen = 1'b1;
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL bp_done_timeout: got %b want 1", seen); end
    total++; if (move_count !== 16'd6) begin bad++; $display("FAIL bp_count: got %0d want 6", move_count); end
  endtask

  task automatic test_clear_mid();
    pulse_clear();
    for (int k = 0; k < 16; k++) batch_moves[32*k +: 32] = 32'h0000_3000 + 32'(k) + 32'd1;
    move_ready  = 1'b1;
    batch_valid = 1'b1;
    tick();
    batch_valid = 1'b0;
    repeat (5) tick();
    total++; if (move_count !== 16'd5) begin bad++; $display("FAIL clr_pre_count: got %0d want 5", move_count); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL clr_level: got %0d want 0", fifo_level); end
    total++; if (move_count !== 16'd0) begin bad++; $display("FAIL clr_count: got %0d want 0", move_count); end
    total++; if (batch_ready !== 1'b1) begin bad++; $display("FAIL clr_ready: got %b want 1", batch_ready); end
    total++; if (move_valid !== 1'b0) begin bad++; $display("FAIL clr_valid: got %b want 0", move_valid); end
    for (int c = 0; c < 16; c++) begin
      total++; if (batch_done !== 1'b0) begin bad++; $display("FAIL clr_no_done %0d: got %b want 0", c, batch_done); end
      total++; if (move_valid !== 1'b0) begin bad++; $display("FAIL clr_idle_valid %0d: got %b want 0", c, move_valid); end
      tick();
    end
  endtask

  task automatic test_clear_blocks_accept();
    batch_valid = 1'b1;
    clear       = 1'b1;
    tick();
    clear       = 1'b0;
    batch_valid = 1'b0;
    total++; if (batch_ready !== 1'b1) begin bad++; $display("FAIL clr_accept_ready: got %b want 1", batch_ready); end
    repeat (4) tick();
    total++; if (move_count !== 16'd0) begin bad++; $display("FAIL clr_accept_count: got %0d want 0", move_count); end
    total++; if (move_valid !== 1'b0) begin bad++; $display("FAIL clr_accept_valid: got %b want 0", move_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [$];
    logic [31:0] exp [4];
    exp[0] = 32'h0A00_0001;
    exp[1] = 32'h0A00_0002;
    exp[2] = 32'h0B00_0003;
    exp[3] = 32'h0B00_0004;
    pulse_clear();
    move_ready  = 1'b1;
    batch_moves = '0;
    batch_moves[32*0  +: 32] = exp[0];
    batch_moves[32*15 +: 32] = exp[1];
    batch_valid = 1'b1;
    tick();
    total++; if (batch_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_a: got %b want 0", batch_ready); end
    batch_moves = '0;
    batch_moves[32*2 +: 32] = exp[2];
    batch_moves[32*7 +: 32] = exp[3];
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c <= 17) begin
        total++; if (batch_ready !== (c == 16)) begin bad++; $display("FAIL b2b_ready E%0d: got %b", c, batch_ready); end
      end
      if (c == 17) batch_valid = 1'b0;
      total++; if (batch_done !== ((c == 16) || (c == 33))) begin bad++; $display("FAIL b2b_done E%0d: got %b", c, batch_done); end
      if (move_valid) got.push_back(move_data);
    end
    total++; if (got.size() !== 4) begin bad++; $display("FAIL b2b_size: got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL b2b_order %0d: got %h want %h", i, got[i], exp[i]); end
    end
    total++; if (move_count !== 16'd4) begin bad++; $display("FAIL b2b_count: got %0d want 4", move_count); end
  endtask

  initial begin
    reset_n     = 1'b0;
    clear       = 1'b0;
    batch_valid = 1'b0;
    batch_moves = '0;
    move_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    test_reset();
    test_sparse();
    test_empty();
    test_backpressure();
    test_clear_mid();
    test_clear_blocks_accept();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
